// File: rtl/bsg_manycore_host_req_scheduler_pkg.sv
// Shared constants and helpers for the host request scheduler slice.
package bsg_manycore_host_req_scheduler_pkg;

  localparam int issued_width_lp = 32;

  // Round-robin pointer advance: next index after idx, wrapping at n.
  function automatic int unsigned hrs_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_manycore_host_req_scheduler_arb.sv
// Round-robin arbiter: the first requester at or after the pointer wins,
// and the pointer moves past the winner only when the grant is consumed.
module bsg_arb_round_robin
  import bsg_manycore_host_req_scheduler_pkg::*;
#(
  parameter int width_p = 4,
  localparam int tag_width_lp = $clog2(width_p)
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    grants_en_i,
  input  logic [width_p-1:0]      reqs_i,
  output logic [width_p-1:0]      grants_o,
  output logic                    v_o,
  output logic [tag_width_lp-1:0] tag_o,
  input  logic                    yumi_i
);

  logic [tag_width_lp-1:0] r_ptr;

  always_comb begin
    logic [tag_width_lp:0] sum;
    v_o   = 1'b0;
    tag_o = '0;
    sum   = '0;
    for (int k = 0; k < width_p; k++) begin
      sum = {1'b0, r_ptr} + (tag_width_lp+1)'(k);
      if (sum >= (tag_width_lp+1)'(width_p))
        sum = sum - (tag_width_lp+1)'(width_p);
      if (!v_o && reqs_i[sum[tag_width_lp-1:0]]) begin
        v_o   = 1'b1;
        tag_o = sum[tag_width_lp-1:0];
      end
    end
  end

  assign grants_o = (grants_en_i && v_o) ? (width_p'(1) << tag_o) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_ptr <= '0;
    else if (yumi_i)
      r_ptr <= tag_width_lp'(hrs_wrap_inc(32'(tag_o), width_p));
  end

endmodule

// File: rtl/bsg_manycore_host_req_scheduler.sv
// Shares one endpoint request port among several host sources, gated by
// endpoint credits, with a fence that drains outstanding requests.
//
//   state  | meaning
//   eRun   | arbitrate and issue; fence requests accepted
//   eDrain | issue blocked; wait for credits-used to reach zero
//   eDone  | fence complete, one-cycle done pulse
module bsg_manycore_host_req_scheduler
  import bsg_manycore_host_req_scheduler_pkg::*;
#(
  parameter int num_req_p              = 4,
  parameter int fifo_width_p           = 32,
  parameter int credit_counter_width_p = $clog2(32+1),
  parameter int credit_limit_p         = (1 << credit_counter_width_p) - 1
)(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p-1:0][fifo_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic                                   v_o,
  output logic [fifo_width_p-1:0]                data_o,
  input  logic                                   ready_i,
  input  logic [credit_counter_width_p-1:0]      out_credits_used_i,
  input  logic                                   fence_v_i,
  output logic                                   fence_ready_o,
  output logic                                   fence_done_o,
  output logic [issued_width_lp-1:0]             issued_count_o
);

  localparam int tag_width_lp = $clog2(num_req_p);

  typedef enum logic [1:0] {eRun, eDrain, eDone} state_e;

  state_e                     r_state;
  logic                       r_fence_ready;
  logic                       r_fence_done;
  logic [issued_width_lp-1:0] r_issued_count;

  logic                    w_credit_ok;
  logic                    w_arb_v;
  logic [tag_width_lp-1:0] w_tag;
  logic                    w_hs;

  assign w_credit_ok = out_credits_used_i < credit_counter_width_p'(credit_limit_p);
  assign v_o         = ~reset_i & (r_state == eRun) & w_credit_ok & w_arb_v;
  assign w_hs        = v_o & ready_i;
  assign data_o      = req_data_i[w_tag];

  // Grant is enabled only by the handshake, so a stalled or fenced cycle
  // never advances the pointer or raises a ready.
  bsg_arb_round_robin #(.width_p(num_req_p)) arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i (w_hs),
    .reqs_i      (req_v_i),
    .grants_o    (req_ready_o),
    .v_o         (w_arb_v),
    .tag_o       (w_tag),
    .yumi_i      (w_hs)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= eRun;
      r_fence_ready <= 1'b1;
      r_fence_done  <= 1'b0;
    end else begin
      case (r_state)
        eRun: if (fence_v_i) begin
          r_state       <= eDrain;
          r_fence_ready <= 1'b0;
        end
        eDrain: if (out_credits_used_i == '0) begin
          r_state      <= eDone;
          r_fence_done <= 1'b1;
        end
        eDone: begin
          r_state       <= eRun;
          r_fence_done  <= 1'b0;
          r_fence_ready <= 1'b1;
        end
        default: begin
          r_state       <= eRun;
          r_fence_done  <= 1'b0;
          r_fence_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_issued_count <= '0;
    else if (w_hs)
      r_issued_count <= r_issued_count + issued_width_lp'(1);
  end

  assign fence_ready_o  = r_fence_ready;
  assign fence_done_o   = r_fence_done;
  assign issued_count_o = r_issued_count;

endmodule

// File: tb/tb_bsg_manycore_host_req_scheduler.sv
// Directed bench for the host request scheduler: round robin, credit stall,
// fences, reset abort and counter wrap.
module tb_bsg_manycore_host_req_scheduler;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int CW  = 4;
  localparam int LIM = 10;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v_i;
  logic [N-1:0][W-1:0] req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              v_o;
  logic [W-1:0]      data_o;
  logic              ready_i;
  logic [CW-1:0]     out_credits_used_i;
  logic              fence_v_i;
  logic              fence_ready_o;
  logic              fence_done_o;
  logic [31:0]       issued_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  bsg_manycore_host_req_scheduler #(
    .num_req_p(N), .fifo_width_p(W),
    .credit_counter_width_p(CW), .credit_limit_p(LIM)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .req_v_i            (req_v_i),
    .req_data_i         (req_data_i),
    .req_ready_o        (req_ready_o),
    .v_o                (v_o),
    .data_o             (data_o),
    .ready_i            (ready_i),
    .out_credits_used_i (out_credits_used_i),
    .fence_v_i          (fence_v_i),
    .fence_ready_o      (fence_ready_o),
    .fence_done_o       (fence_done_o),
    .issued_count_o     (issued_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_data_i[i] = W'(32'hA000 + i);
    reset_i = 1'b1; req_v_i = '1; ready_i = 1'b1;
    out_credits_used_i = '0; fence_v_i = 1'b0;

    // reset
    @(negedge clk); #1;
    chk("rst_v", 32'(v_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_done", 32'(fence_done_o), 0);
    @(negedge clk); #1;
    chk("rst_fready", 32'(fence_ready_o), 1);
    chk("rst_cnt", issued_count_o, 0);

    // round robin 0,1,2,3,0
    @(negedge clk); reset_i = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("rr_v", 32'(v_o), 1);
      chk("rr_grant", 32'(req_ready_o), 32'(1) << (k % 4));
      chk("rr_data", 32'(data_o), 32'hA000 + (k % 4));
    end
    @(negedge clk); #1;
    chk("rr_cnt", issued_count_o, 5);

    // credit stall at the limit, release at limit-1
    out_credits_used_i = CW'(LIM); #1;
    chk("stall_v", 32'(v_o), 0);
    chk("stall_ready", 32'(req_ready_o), 0);
    @(negedge clk); #1;
    chk("stall_cnt", issued_count_o, 5);
    out_credits_used_i = CW'(LIM - 1); #1;
    chk("unstall_v", 32'(v_o), 1);
    chk("unstall_grant", 32'(req_ready_o), 2);
    chk("unstall_data", 32'(data_o), 32'hA001);
    @(negedge clk); #1;
    chk("unstall_cnt", issued_count_o, 6);

    // endpoint back-pressure: valid without ready, no grant, pointer holds
    ready_i = 1'b0; #1;
    chk("bp_v", 32'(v_o), 1);
    chk("bp_ready", 32'(req_ready_o), 0);
    @(negedge clk); #1;
    chk("bp_cnt", issued_count_o, 6);
    ready_i = 1'b1; #1;
    chk("bp_grant", 32'(req_ready_o), 4);

    // fence with drain 3,2,1,0; handshake allowed in the accept cycle
    @(negedge clk); out_credits_used_i = 4'd3; fence_v_i = 1'b1; #1;
    chk("fa_fready", 32'(fence_ready_o), 1);
    chk("fa_grant", 32'(req_ready_o), 8);
    @(negedge clk); out_credits_used_i = 4'd2; #1;
    chk("fd2_v", 32'(v_o), 0);
    chk("fd2_ready", 32'(req_ready_o), 0);
    chk("fd2_fready", 32'(fence_ready_o), 0);
    chk("fd2_done", 32'(fence_done_o), 0);
    chk("fd2_cnt", issued_count_o, 8);
    @(negedge clk); out_credits_used_i = 4'd1; #1;
    chk("fd1_v", 32'(v_o), 0);
    chk("fd1_done", 32'(fence_done_o), 0);
    @(negedge clk); out_credits_used_i = 4'd0; #1;
    chk("fd0_v", 32'(v_o), 0);
    chk("fd0_done", 32'(fence_done_o), 0);
    @(negedge clk); fence_v_i = 1'b0; #1;
    chk("fdone_pulse", 32'(fence_done_o), 1);
    chk("fdone_v", 32'(v_o), 0);
    @(negedge clk); #1;
    chk("fpost_done", 32'(fence_done_o), 0);
    chk("fpost_fready", 32'(fence_ready_o), 1);
    chk("fpost_grant", 32'(req_ready_o), 1);
    @(negedge clk); #1;
    chk("fpost_noqueue", 32'(fence_ready_o), 1);
    chk("fpost_cnt", issued_count_o, 9);

    // immediate fence with zero credits
    ready_i = 1'b0; fence_v_i = 1'b1; #1;
    @(negedge clk); fence_v_i = 1'b0; #1;
    chk("if_drain_done", 32'(fence_done_o), 0);
    chk("if_drain_fready", 32'(fence_ready_o), 0);
    @(negedge clk); #1;
    chk("if_done", 32'(fence_done_o), 1);
    @(negedge clk); #1;
    chk("if_after_done", 32'(fence_done_o), 0);
    chk("if_after_fready", 32'(fence_ready_o), 1);

    // reset while draining aborts the fence
    out_credits_used_i = 4'd5; fence_v_i = 1'b1; #1;
    @(negedge clk); fence_v_i = 1'b0; #1;
    chk("rf_in_drain", 32'(fence_ready_o), 0);
    reset_i = 1'b1; out_credits_used_i = '0; ready_i = 1'b1; #1;
    chk("rf_rst_v", 32'(v_o), 0);
    @(negedge clk); #1;
    chk("rf_rst_done", 32'(fence_done_o), 0);
    chk("rf_rst_fready", 32'(fence_ready_o), 1);
    reset_i = 1'b0; #1;
    chk("rf_cnt", issued_count_o, 0);
    chk("rf_grant", 32'(req_ready_o), 1);
    @(negedge clk); #1;
    chk("rf_post_done", 32'(fence_done_o), 0);
    chk("rf_post_cnt", issued_count_o, 1);

    // pointer to 2 via source 1, preload count, then wrap
    req_v_i = 4'b0010; #1;
    chk("wr_setup", 32'(req_ready_o), 2);
    @(negedge clk); ready_i = 1'b0; req_v_i = '0;
    force dut.r_issued_count = 32'hFFFF_FFFF;
    #1 release dut.r_issued_count;
    #1;
    chk("wr_preload", issued_count_o, 32'hFFFF_FFFF);
    @(negedge clk); req_v_i = 4'b1010; ready_i = 1'b1; #1;
    chk("wr_grant3", 32'(req_ready_o), 8);
    chk("wr_data3", 32'(data_o), 32'hA003);
    @(negedge clk); #1;
    chk("wr_wrap", issued_count_o, 0);
    chk("wr_grant1", 32'(req_ready_o), 2);
    chk("wr_data1", 32'(data_o), 32'hA001);
    @(negedge clk); #1;
    chk("wr_cnt1", issued_count_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_host_req_scheduler.md
BSG_MANYCORE_HOST_REQ_SCHEDULER -- requirements
Module: bsg_manycore_host_req_scheduler

Interface
REQ-001 The block SHALL take parameter num_req_p, default "inv", meaning the number of host request sources sharing one endpoint request port (legal range 2..8).
REQ-002 The block SHALL take parameter fifo_width_p, default "inv", meaning the packet width in bits.
REQ-003 The block SHALL take parameter credit_counter_width_p, default `BSG_WIDTH(32), meaning the width of the endpoint credits-used count.
REQ-004 The block SHALL take parameter credit_limit_p, default (1<<credit_counter_width_p)-1, meaning the credits-used value at which issue stalls.
REQ-005 clk_i  input  1  single clock; all logic is on posedge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 req_v_i  input  num_req_p  per-source packet valid.
REQ-008 req_data_i  input  num_req_p x fifo_width_p  per-source packet.
REQ-009 req_ready_o  output  num_req_p  per-source accept; a source's packet transfers when v&ready.
REQ-010 v_o  output  1  packet valid to the endpoint request input.
REQ-011 data_o  output  fifo_width_p  packet to the endpoint.
REQ-012 ready_i  input  1  endpoint request ready.
REQ-013 out_credits_used_i  input  credit_counter_width_p  endpoint outstanding-request count.
REQ-014 fence_v_i  input  1  fence request; sampled while fence_ready_o=1.
REQ-015 fence_ready_o  output  1  high only in state eRun.
REQ-016 fence_done_o  output  1  one-cycle completion pulse.
REQ-017 issued_count_o  output  32  total packets issued; wraps modulo 2^32.

Function
REQ-018 The FSM SHALL have the states eRun, eDrain and eDone.
- eRun->eDrain when fence_v_i&fence_ready_o.
- eDrain->eDone when out_credits_used_i==0.
- eDone->eRun unconditionally, after one cycle.
REQ-019 credit_ok SHALL be (out_credits_used_i < credit_limit_p), compared unsigned at full width.
REQ-020 v_o SHALL equal (state==eRun) & credit_ok & (|req_v_i), combinationally; there is zero-cycle latency from source to endpoint.
REQ-021 The winner SHALL be the first valid source at or after rr_ptr in ascending index order, wrapping from num_req_p-1 to 0.
REQ-022 data_o SHALL equal req_data_i of the winner; when v_o=0, data_o is don't-care.
REQ-023 req_ready_o[i] SHALL be 1 only for the winner, and only when v_o&ready_i.
REQ-024 At most one req_ready_o bit SHALL be high in any cycle; req_ready_o SHALL never depend on the source's own req_v_i being asserted after the grant.
REQ-025 On a handshake (v_o&ready_i), rr_ptr SHALL load winner+1 mod num_req_p; otherwise rr_ptr holds.
REQ-026 On each handshake, issued_count_o SHALL increment by 1, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-027 A handshake SHALL be allowed in the same cycle that a fence is accepted; from the next cycle, v_o=0 until the FSM returns to eRun.
REQ-028 fence_done_o SHALL be 1 exactly in state eDone.
REQ-029 If out_credits_used_i==0 when the fence is accepted, the FSM SHALL still pass through eDrain for one cycle, so fence_done_o occurs 2 cycles after acceptance.
REQ-030 When credit_ok=0 in eRun, v_o SHALL be 0 and rr_ptr SHALL hold; there is no starvation reshuffle.
REQ-031 fence_v_i SHALL be ignored outside eRun; no fence is queued.
REQ-032 ready_i SHALL be allowed to drop with v_o high; the block SHALL re-arbitrate every cycle, with no grant lock, because packets are single-beat.

Reset
REQ-033 While reset_i=1 at a posedge, the block SHALL load state=eRun, rr_ptr=0 and issued_count_o=0.
REQ-034 During and after reset, the outputs SHALL be:
- fence_done_o=0;
- fence_ready_o=1 in the first cycle after reset;
- v_o and req_ready_o=0 while reset_i=1.
REQ-035 Reset asserted in eDrain or eDone SHALL abort the fence, with no fence_done_o pulse.

Structure
REQ-036 The state enum SHALL be local to the module; no new shared-package typedefs are needed, and the credit width comes from the parameter.
REQ-037 Arbitration SHALL use the existing basejump round-robin arbiter bsg_arb_round_robin as the single sub-module; the FSM, credit gating and counter stay in this module.

Verification
REQ-038 Round robin: num_req_p=4, all sources valid, ready_i=1, credits 0 -> grant order is 0,1,2,3,0 on consecutive cycles, and issued_count_o=5 after 5 cycles.
REQ-039 Credit stall: out_credits_used_i=credit_limit_p with sources valid -> v_o=0 and req_ready_o=0; lower it to limit-1 -> v_o=1 in the same cycle.
REQ-040 Fence drain: accept a fence with credits=3, then step credits 2,1,0 -> v_o=0 throughout, and fence_done_o pulses exactly once, the cycle after credits read 0.
REQ-041 Immediate fence: fence accepted with credits=0 -> fence_done_o is high exactly 2 cycles later, and fence_ready_o is back to 1 the cycle after that.
REQ-042 Reset mid-fence: assert reset_i in eDrain -> fence_done_o is never asserted, and after reset fence_ready_o=1, rr_ptr=0 (source 0 wins first) and issued_count_o=0.
REQ-043 Wrap: preload issued_count_o to 0xFFFF_FFFF via a forced handshake sequence -> the next handshake gives 0; with sources 1 and 3 only valid and rr_ptr=2 -> source 3 wins, then source 1.
